// File: rtl/hms_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hms_pkg
// Brief   : Shared encodings and constants for the min:sec alarm controller.
// Revision: 1.0 - initial release
// ============================================================================
package hms_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK = 2'd0,
        MODE_SETUP = 2'd1,
        MODE_ALARM = 2'd2
    } mode_t;

    typedef enum logic [0:0] {
        POS_SEC = 1'b0,
        POS_MIN = 1'b1
    } pos_t;

    typedef enum logic [0:0] {
        RING_IDLE   = 1'b0,
        RING_ACTIVE = 1'b1
    } ring_t;

    // Auto-repeat: first extra event after REP_FIRST strobes held, then every REP_NEXT.
    localparam int REP_FIRST = 50;
    localparam int REP_NEXT  = 10;

endpackage
`default_nettype wire

// File: rtl/hms_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module  : hms_btn_debounce
// Brief   : Synchronises one active-low button, confirms it over two strobes,
//           and emits the pressed level plus a one-clk press pulse.
// Revision: 1.0 - initial release
// ============================================================================
module hms_btn_debounce (
    input  logic clk,
    input  logic rst_n,
    input  logic i_strobe,
    input  logic i_raw,
    output logic o_pressed,
    output logic o_press
);

    logic [1:0] r_sync;
    logic       r_sample;
    logic       r_state;
    logic       r_press;
    logic       w_smp;

    // Sampled value in "pressed" polarity; raw input is active-low.
    assign w_smp = ~r_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= 2'b11;
            r_sample <= 1'b0;
            r_state  <= 1'b0;
            r_press  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_raw};
            r_press <= 1'b0;
            if (i_strobe) begin
                r_sample <= w_smp;
                if ((w_smp == r_sample) && (w_smp != r_state)) begin
                    r_state <= w_smp;
                    r_press <= w_smp;
                end
            end
        end
    end

    assign o_pressed = r_state;
    assign o_press   = r_press;

endmodule
`default_nettype wire

// File: rtl/hms_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module  : hms_ctrl_fsm
// Brief   : Single-clock controller for the min:sec alarm clock: button
//           debounce, mode/position FSMs, counter enables and alarm ring FSM.
//           Optional sw2 auto-repeat enabled by defining HMS_AUTO_REPEAT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module hms_ctrl_fsm
    import hms_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int DEB_DIV  = 500000,
    parameter int RING_SEC = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_sw,
    input  logic       i_sec_is_59,
    input  logic       i_alarm_match,
    output logic [1:0] o_mode,
    output logic       o_position,
    output logic       o_alarm_en,
    output logic       o_sec_inc,
    output logic       o_min_inc,
    output logic       o_alarm_sec_inc,
    output logic       o_alarm_min_inc,
    output logic       o_ring
);

    localparam int c_tick_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_deb_w  = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam int c_ring_w = $clog2(RING_SEC + 1);

    logic [c_tick_w-1:0] r_tick_cnt;
    logic [c_deb_w-1:0]  r_deb_cnt;
    logic [c_ring_w-1:0] r_ring_cnt, w_ring_cnt_nxt;
    mode_t               r_mode, w_mode_nxt;
    pos_t                r_pos, w_pos_nxt;
    ring_t               r_ring, w_ring_nxt;
    logic                r_alarm_en, w_alarm_en_nxt;
    logic                r_match_d;
    logic                r_sec_inc, r_min_inc, r_asec_inc, r_amin_inc;
    logic                w_sec_inc, w_min_inc, w_asec_inc, w_amin_inc;
    logic                w_tick, w_strobe, w_match_rise, w_rep;
    logic                w_p0, w_p1, w_p2, w_p3;
    logic [3:0]          w_pressed, w_press;

    // The tick counter is parked at 0 during SETUP so time resumes a full period later.
    assign w_tick   = (r_mode != MODE_SETUP) && (r_tick_cnt == c_tick_w'(TICK_DIV - 1));
    assign w_strobe = (r_deb_cnt == c_deb_w'(DEB_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_deb_cnt  <= '0;
        end else begin
            if (r_mode == MODE_SETUP || w_tick)
                r_tick_cnt <= '0;
            else
                r_tick_cnt <= r_tick_cnt + c_tick_w'(1);
            if (w_strobe)
                r_deb_cnt <= '0;
            else
                r_deb_cnt <= r_deb_cnt + c_deb_w'(1);
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        hms_btn_debounce u_deb (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_strobe  (w_strobe),
            .i_raw     (i_sw[gi]),
            .o_pressed (w_pressed[gi]),
            .o_press   (w_press[gi])
        );
    end

`ifdef HMS_AUTO_REPEAT_EN
    localparam int c_rep_w = $clog2(REP_FIRST + 1);
    logic [c_rep_w-1:0] r_rep_cnt;
    logic               r_rep;
    logic [2:0]         w_pressed_unused;

    assign w_pressed_unused = {w_pressed[3], w_pressed[1:0]};

    // Repeat events only reach the counters in SETUP/ALARM; the increment decode below ignores CLOCK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt <= '0;
            r_rep     <= 1'b0;
        end else if (!w_pressed[2]) begin
            r_rep_cnt <= '0;
            r_rep     <= 1'b0;
        end else begin
            r_rep <= 1'b0;
            if (w_strobe) begin
                if (r_rep_cnt == c_rep_w'(REP_FIRST - 1)) begin
                    r_rep_cnt <= c_rep_w'(REP_FIRST - REP_NEXT);
                    r_rep     <= 1'b1;
                end else begin
                    r_rep_cnt <= r_rep_cnt + c_rep_w'(1);
                end
            end
        end
    end
    assign w_rep = r_rep;
`else
    logic [3:0] w_pressed_unused;
    assign w_pressed_unused = w_pressed;
    assign w_rep            = 1'b0;
`endif

    assign w_p0         = w_press[0];
    assign w_p1         = w_press[1] & ~w_press[0];
    assign w_p2         = (w_press[2] | w_rep) & ~w_press[0] & ~w_press[1];
    assign w_p3         = w_press[3];
    assign w_match_rise = i_alarm_match & ~r_match_d;

    always_comb begin
        w_mode_nxt     = r_mode;
        w_pos_nxt      = r_pos;
        w_alarm_en_nxt = r_alarm_en;
        w_ring_nxt     = r_ring;
        w_ring_cnt_nxt = r_ring_cnt;
        w_sec_inc      = 1'b0;
        w_min_inc      = 1'b0;
        w_asec_inc     = 1'b0;
        w_amin_inc     = 1'b0;

        case (r_mode)
            MODE_CLOCK: if (w_p0) w_mode_nxt = MODE_SETUP;
            MODE_SETUP: if (w_p0) w_mode_nxt = MODE_ALARM;
            MODE_ALARM: if (w_p0) w_mode_nxt = MODE_CLOCK;
            default:    w_mode_nxt = MODE_CLOCK;
        endcase

        if (w_mode_nxt != r_mode)
            w_pos_nxt = POS_SEC;
        else if (w_p1)
            w_pos_nxt = (r_pos == POS_SEC) ? POS_MIN : POS_SEC;

        w_sec_inc = w_tick;
        w_min_inc = w_tick & i_sec_is_59;
        if (w_p2) begin
            case (r_mode)
                MODE_SETUP: begin
                    if (r_pos == POS_SEC) w_sec_inc = 1'b1;
                    else                  w_min_inc = 1'b1;
                end
                MODE_ALARM: begin
                    if (r_pos == POS_SEC) w_asec_inc = 1'b1;
                    else                  w_amin_inc = 1'b1;
                end
                default: ;
            endcase
        end

        if (r_ring == RING_IDLE) begin
            if (w_p3)
                w_alarm_en_nxt = ~r_alarm_en;
            if (w_alarm_en_nxt && w_match_rise && (r_mode != MODE_SETUP)) begin
                w_ring_nxt     = RING_ACTIVE;
                w_ring_cnt_nxt = '0;
            end
        end else begin
            if (w_tick)
                w_ring_cnt_nxt = r_ring_cnt + c_ring_w'(1);
            if (w_p3 || !r_alarm_en || (w_tick && (r_ring_cnt == c_ring_w'(RING_SEC - 1))))
                w_ring_nxt = RING_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode     <= MODE_CLOCK;
            r_pos      <= POS_SEC;
            r_alarm_en <= 1'b0;
            r_ring     <= RING_IDLE;
            r_ring_cnt <= '0;
            r_match_d  <= 1'b0;
            r_sec_inc  <= 1'b0;
            r_min_inc  <= 1'b0;
            r_asec_inc <= 1'b0;
            r_amin_inc <= 1'b0;
        end else begin
            r_mode     <= w_mode_nxt;
            r_pos      <= w_pos_nxt;
            r_alarm_en <= w_alarm_en_nxt;
            r_ring     <= w_ring_nxt;
            r_ring_cnt <= w_ring_cnt_nxt;
            r_match_d  <= i_alarm_match;
            r_sec_inc  <= w_sec_inc;
            r_min_inc  <= w_min_inc;
            r_asec_inc <= w_asec_inc;
            r_amin_inc <= w_amin_inc;
        end
    end

    assign o_mode          = r_mode;
    assign o_position      = r_pos;
    assign o_alarm_en      = r_alarm_en;
    assign o_ring          = (r_ring == RING_ACTIVE);
    assign o_sec_inc       = r_sec_inc;
    assign o_min_inc       = r_min_inc;
    assign o_alarm_sec_inc = r_asec_inc;
    assign o_alarm_min_inc = r_amin_inc;

endmodule
`default_nettype wire

// File: doc/hms_ctrl_fsm.md
Name: hms_ctrl_fsm

Overview:
Synchronous replacement for the gated-clock controller of the min:sec alarm clock.
- Debounces the four buttons and runs the mode/position state machines.
- Emits single-cycle clock *enables* (never derived clocks) to the time and alarm counters.
- Owns the alarm-ring state machine that gates the buzzer.
- Sits between the board buttons and the minsec/buzzer datapath; everything runs on clk.

Parameters:
TICK_DIV, 50000000, clk cycles per 1 Hz timekeeping tick
DEB_DIV, 500000, clk cycles per button sample strobe (100 Hz)
RING_SEC, 30, ticks after which an unanswered alarm stops ringing

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  asynchronous active-low reset
i_sw  in  4  raw buttons, active-low: [0] mode, [1] position, [2] increment, [3] alarm on/off
i_sec_is_59  in  1  level, time-seconds counter currently holds 59
i_alarm_match  in  1  level, current time equals alarm time
o_mode  out  2  0=CLOCK, 1=SETUP, 2=ALARM
o_position  out  1  0=SEC, 1=MIN
o_alarm_en  out  1  alarm armed
o_sec_inc  out  1  one-cycle enable, time seconds +1
o_min_inc  out  1  one-cycle enable, time minutes +1
o_alarm_sec_inc  out  1  one-cycle enable, alarm seconds +1
o_alarm_min_inc  out  1  one-cycle enable, alarm minutes +1
o_ring  out  1  buzzer enable

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0: mode CLOCK, position SEC, alarm_en 0, ring IDLE.
  - Tick and sample counters cleared.
- Tick: counter 0..TICK_DIV-1; tick pulse for one clk on wrap.
  - In SETUP the counter is held at 0, so time resumes exactly TICK_DIV cycles after leaving SETUP.
- Debounce, per button:
  - Sample on each DEB_DIV strobe.
  - State flips only after two consecutive equal samples.
  - A press event is one clk pulse on the released->pressed transition, issued the cycle after the confirming strobe.
- Mode FSM: each sw0 press advances CLOCK->SETUP->ALARM->CLOCK. Encoding 3 is unreachable; if reached, it returns to CLOCK next cycle.
- Position: toggles on each sw1 press. It is forced to SEC on any mode change.
- Priority when presses coincide in one cycle: sw0 > sw1 > sw2. Lower-priority presses in that cycle are dropped. sw3 is independent of this ordering.
- CLOCK and ALARM modes:
  - o_sec_inc = tick.
  - o_min_inc = tick & i_sec_is_59, in the same cycle.
- SETUP mode, sw2 press:
  - POS_SEC: o_sec_inc only; no carry into minutes.
  - POS_MIN: o_min_inc only.
- ALARM mode, sw2 press: POS_SEC -> o_alarm_sec_inc, POS_MIN -> o_alarm_min_inc.
  - May coincide with tick-driven o_sec_inc; both are asserted.
- sw2 in CLOCK mode: ignored.
- sw3 press:
  - If ringing: ring goes to IDLE and alarm_en is unchanged.
  - Otherwise: alarm_en toggles.
- Ring FSM, IDLE -> RING when all hold: alarm_en=1, rising edge of i_alarm_match (registered compare), mode != SETUP.
- Ring FSM, RING -> IDLE on any of: sw3 press, alarm_en=0, RING_SEC ticks counted in RING.
  - Ring tick counter clears on entry.
- o_ring = (state==RING). Registered, so it rises 1 clk after the match edge.
- Mid-operation reset: every state and counter returns to its reset value immediately; no pending pulses survive.
- All enables are at most one clk wide and never glitch (registered).

Optional Feature:
HMS_AUTO_REPEAT_EN
- Defined: holding sw2 for 50 strobes generates an extra press event every further 10 strobes while held. Applies in SETUP and ALARM only.
- Undefined: exactly one event per press.

Decomposition:
- Package hms_pkg holds:
  - Mode encodings MODE_CLOCK/SETUP/ALARM.
  - POS_SEC/POS_MIN.
  - Ring state encodings RING_IDLE/RING_ACTIVE.
  - Repeat constants (50, 10).
- One sub-module, hms_btn_debounce (clk, rst_n, strobe, raw -> pressed level, press pulse), instanced four times.

Test Plan:
Bench uses TICK_DIV=20, DEB_DIV=4.
- Reset release, no buttons, 3 ticks -> o_sec_inc pulses exactly every 20 clk; mode=0, alarm_en=0, o_ring=0.
- i_sec_is_59=1 at tick -> o_sec_inc and o_min_inc high in the same clk; i_sec_is_59=0 -> o_min_inc never asserts.
- sw0 press, sw1 press, 3 sw2 presses -> SETUP, MIN; three o_min_inc pulses, zero o_sec_inc; sw0 again -> ALARM with position=SEC.
- Bouncing sw2 (toggling each clk for 3 clk, then held 40 clk) -> exactly one increment pulse.
- alarm_en=1, i_alarm_match rises in CLOCK -> o_ring=1 next clk; sw3 press -> o_ring=0, alarm_en still 1; repeat with no press -> o_ring drops after 30 ticks.
- sw0 and sw2 pressed in the same sample -> mode advances, no increment; rst_n pulsed while ringing -> o_ring=0 and mode=0 asynchronously.
